mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 256, cache-line width.
REQ-003 Parameter RR_EN, default 1: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-004 Parameter TIMEOUT_CYC, default 1023: BUSY cycles without ack before err_o sets; 0 disables the timeout.
REQ-005 clk_i  in  1  single clock; all state updates on posedge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 p0_enable_i / p1_enable_i  in  1  request level per port (p0 = dcache, p1 = icache), held until that port's ack.
REQ-008 p0_write_i / p1_write_i  in  1  1 = line write, 0 = line read.
REQ-009 p0_addr_i / p1_addr_i  in  ADDR_W  line address.
REQ-010 p0_data_i / p1_data_i  in  DATA_W  write line.
REQ-011 p0_data_o / p1_data_o  out  DATA_W  read line; mem_data_i broadcast to both ports.
REQ-012 p0_ack_o / p1_ack_o  out  1  completion, granted port only.
REQ-013 mem_enable_o, mem_write_o  out  1 each; mem_addr_o  out  ADDR_W; mem_data_o  out  DATA_W: memory request.
REQ-014 mem_data_i  in  DATA_W; mem_ack_i  in  1  one-cycle completion pulse.
REQ-015 grant_o  out  2  one-hot current owner, 00 when none; busy_o  out  1  state != IDLE; err_o  out  1  sticky timeout flag.

Function
REQ-016 States SHALL be IDLE, BUSY and RELEASE; the encoding is a 2-bit enumeration.
REQ-017 IDLE: no enable high -> stay; any enable high -> register grant, go BUSY next cycle.
REQ-018 Selection, RR_EN=1: single requester wins; both requesting -> port not granted last; last-granted pointer updates at each grant.
REQ-019 Selection, RR_EN=0: both requesting -> port 0 wins.
REQ-020 BUSY: mem_enable_o = owner's enable; mem_write_o, mem_addr_o, mem_data_o = owner's inputs via combinational mux on registered grant; non-owner inputs SHALL be ignored.
REQ-021 Latency: enable sampled high at posedge N -> mem_enable_o high in cycle N+1.
REQ-022 BUSY with mem_ack_i high -> owner's ack_o high the same cycle (combinational), other port's ack_o low, next state RELEASE.
REQ-023 RELEASE lasts exactly one cycle: mem_enable_o = 0, grant_o = 00, requests ignored; then IDLE.
REQ-024 Back-to-back minimum: ack in cycle M -> next grant sampled at posedge M+2 -> mem_enable_o high in M+3.
REQ-025 mem_ack_i outside BUSY SHALL be ignored: no ack_o, no state change.
REQ-026 Owner dropping enable in BUSY before ack SHALL force mem_enable_o low, keep state BUSY and keep grant; it is not an abort.
REQ-027 Timeout counter: clears on entry to BUSY, counts each BUSY cycle, saturates at TIMEOUT_CYC; reaching TIMEOUT_CYC (nonzero) sets err_o; arbiter keeps waiting for ack.
REQ-028 Counter width SHALL be $clog2(TIMEOUT_CYC+1), minimum 1.
REQ-029 A simultaneous new request and ack in BUSY SHALL complete the current transfer first; the new request is arbitrated in IDLE.

Reset
REQ-030 rst_i high at posedge -> state IDLE, grant 00, last-granted pointer = port 1 (port 0 wins first tie), counter 0, err_o 0; applies mid-transaction.
REQ-031 During and after reset, before any grant: mem_enable_o, mem_write_o, both ack_o, busy_o = 0; mem_addr_o and mem_data_o = 0.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enumeration and the ADDR_W/DATA_W default constants.
REQ-033 One sub-module, mem_arbiter_pick, SHALL be used: combinational 2-way chooser (requests, last pointer, RR_EN -> one-hot grant); FSM, counter and muxes stay in mem_arbiter.

Verification
REQ-034 p0 read only, addr 0x0000_0400, ack after 10 cycles -> mem_enable_o high one cycle after request, mem_addr_o 0x400, p0_ack_o pulses with ack, p1_ack_o stays 0.
REQ-035 p0 and p1 both request from reset, RR_EN=1, each holding until acked -> grant order p0, p1, p0, p1; each next mem_enable_o rises exactly 3 cycles after the prior ack.
REQ-036 Same stimulus with RR_EN=0 and p0 re-requesting immediately -> p0 always wins; p1 only granted when p0 idle in IDLE.
REQ-037 p1 write, data 256'hA5..A5, addr 0x0000_1FE0 -> mem_write_o 1, mem_data_o and mem_addr_o match p1 inputs for whole BUSY.
REQ-038 TIMEOUT_CYC=8, memory never acks -> err_o rises after 8 BUSY cycles and stays high, busy_o stays 1; rst_i pulse -> err_o 0, busy_o 0, mem_enable_o 0 on next cycle.
REQ-039 Spurious mem_ack_i in IDLE and in RELEASE -> no ack_o, state unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port cache-line memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way chooser: requests plus last-granted pointer -> one-hot grant.
module mem_arbiter_pick #(
  parameter int unsigned RR_EN = 1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,   // 0: port 0 granted last, 1: port 1 granted last
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (req_i == 2'b11) begin
      // On a tie, round-robin favours the port not granted last; fixed priority favours port 0.
      if ((RR_EN != 0) && !last_i) grant_o = 2'b10;
      else                         grant_o = 2'b01;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (dcache/icache) arbiter for a single line-wide memory port with timeout flag.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned RR_EN       = 1,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       pick;
  logic             in_busy;

  mem_arbiter_pick #(.RR_EN(RR_EN)) u_pick (
    .req_i   ({p1_enable_i, p0_enable_i}),
    .last_i  (last_q),
    .grant_o (pick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p0_enable_i || p1_enable_i) begin
          grant_d = pick;
          last_d  = pick[1];
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) err_d = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // grant_q is non-zero only in BUSY, so the mux alone zeroes the memory side elsewhere.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (grant_q[0]) begin
      mem_enable_o = p0_enable_i;
      mem_write_o  = p0_write_i;
      mem_addr_o   = p0_addr_i;
      mem_data_o   = p0_data_i;
    end else if (grant_q[1]) begin
      mem_enable_o = p1_enable_i;
      mem_write_o  = p1_write_i;
      mem_addr_o   = p1_addr_i;
      mem_data_o   = p1_data_i;
    end
  end

  assign in_busy   = (state_q == ST_BUSY);
  assign p0_ack_o  = in_busy & mem_ack_i & grant_q[0];
  assign p1_ack_o  = in_busy & mem_ack_i & grant_q[1];
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin/timeout-8 instance and a fixed-priority/no-timeout
// instance share stimulus and are each compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en0, en1, wr0, wr1, mack;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1, mdi;

  logic [DW-1:0] o_p0d [2];
  logic [DW-1:0] o_p1d [2];
  logic [DW-1:0] o_md  [2];
  logic [AW-1:0] o_ma  [2];
  logic [1:0]    o_g   [2];
  logic          o_ack0[2], o_ack1[2], o_men[2], o_mwr[2], o_busy[2], o_err[2];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .TIMEOUT_CYC(8)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(en0), .p0_write_i(wr0), .p0_addr_i(a0), .p0_data_i(d0),
    .p0_data_o(o_p0d[0]), .p0_ack_o(o_ack0[0]),
    .p1_enable_i(en1), .p1_write_i(wr1), .p1_addr_i(a1), .p1_data_i(d1),
    .p1_data_o(o_p1d[0]), .p1_ack_o(o_ack1[0]),
    .mem_enable_o(o_men[0]), .mem_write_o(o_mwr[0]), .mem_addr_o(o_ma[0]), .mem_data_o(o_md[0]),
    .mem_data_i(mdi), .mem_ack_i(mack),
    .grant_o(o_g[0]), .busy_o(o_busy[0]), .err_o(o_err[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0), .TIMEOUT_CYC(0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(en0), .p0_write_i(wr0), .p0_addr_i(a0), .p0_data_i(d0),
    .p0_data_o(o_p0d[1]), .p0_ack_o(o_ack0[1]),
    .p1_enable_i(en1), .p1_write_i(wr1), .p1_addr_i(a1), .p1_data_i(d1),
    .p1_data_o(o_p1d[1]), .p1_ack_o(o_ack1[1]),
    .mem_enable_o(o_men[1]), .mem_write_o(o_mwr[1]), .mem_addr_o(o_ma[1]), .mem_data_o(o_md[1]),
    .mem_data_i(mdi), .mem_ack_i(mack),
    .grant_o(o_g[1]), .busy_o(o_busy[1]), .err_o(o_err[1])
  );

  // Reference model per instance: phase 0 idle, 1 transfer in flight, 2 one-cycle release.
  int ph[2], own[2], lst[2], cnt[2];
  bit merr[2];
  int n_vec = 0, n_err = 0;
  bit chk_on = 1'b0;
  bit obs_en_rr, lack0, lack1;

  function automatic bit is_rr(int d);  return d == 0;       endfunction
  function automatic int to_of(int d);  return (d == 0) ? 8 : 0; endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(int d);
    logic [1:0]    g;
    logic          inb, e_own, w_own;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [7:0]    ectl, octl;
    inb   = (ph[d] == 1);
    g     = (own[d] == 0) ? 2'b01 : (own[d] == 1) ? 2'b10 : 2'b00;
    e_own = (own[d] == 0) ? en0 : (own[d] == 1) ? en1 : 1'b0;
    w_own = (own[d] == 0) ? wr0 : (own[d] == 1) ? wr1 : 1'b0;
    ea    = !inb ? '0 : (own[d] == 0) ? a0 : a1;
    ed    = !inb ? '0 : (own[d] == 0) ? d0 : d1;
    ectl  = {g, ph[d] != 0, merr[d], inb & e_own, inb & w_own,
             inb & mack & (own[d] == 0), inb & mack & (own[d] == 1)};
    octl  = {o_g[d], o_busy[d], o_err[d], o_men[d], o_mwr[d], o_ack0[d], o_ack1[d]};
    chk($sformatf("ctrl[%0d]", d), DW'(octl), DW'(ectl));
    chk($sformatf("mem_addr[%0d]", d), DW'(o_ma[d]), DW'(ea));
    chk($sformatf("mem_data[%0d]", d), o_md[d], ed);
    chk($sformatf("rd_data[%0d]", d), o_p0d[d] ^ o_p1d[d] ^ o_p1d[d], mdi);
    chk($sformatf("rd_data1[%0d]", d), o_p1d[d], mdi);
  endtask

  task automatic advance(int d);
    if (rst) begin
      ph[d] = 0; own[d] = -1; lst[d] = 1; cnt[d] = 0; merr[d] = 1'b0;
    end else if (ph[d] == 0) begin
      if (en0 || en1) begin
        if (en0 && en1) own[d] = (is_rr(d) && lst[d] == 0) ? 1 : 0;
        else            own[d] = en0 ? 0 : 1;
        lst[d] = own[d]; cnt[d] = 0; ph[d] = 1;
      end
    end else if (ph[d] == 1) begin
      if (mack) begin
        ph[d] = 2; own[d] = -1;
      end else if (to_of(d) != 0 && cnt[d] < to_of(d)) begin
        cnt[d]++;
        if (cnt[d] == to_of(d)) merr[d] = 1'b1;
      end
    end else begin
      ph[d] = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      check_dut(0);
      check_dut(1);
    end
    obs_en_rr = o_men[0];
    lack0 = (ph[0] == 1) && mack && (own[0] == 0);
    lack1 = (ph[0] == 1) && mack && (own[0] == 1);
    advance(0);
    advance(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; mdi = '0; mack = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; own[d] = -1; lst[d] = 1; cnt[d] = 0; merr[d] = 1'b0;
    end

    // Reset state, then a single p0 read acked after ten BUSY cycles.
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    a0 = 32'h0000_0400; d0 = rnd256(); en0 = 1'b1; mdi = rnd256();
    tick();
    chk("lat_men", DW'(o_men[0]), DW'(1'b1));
    chk("lat_addr", DW'(o_ma[0]), DW'(32'h400));
    repeat (9) tick();
    mack = 1'b1;
    tick();
    en0 = 1'b0;

    // Spurious acks in RELEASE and IDLE.
    tick();
    tick();
    mack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Both ports hold requests continuously: RR alternates, fixed priority sticks to p0.
    en0 = 1'b1; en1 = 1'b1; a0 = $urandom; a1 = $urandom; d0 = rnd256(); d1 = rnd256();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", DW'(o_g[0]), DW'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk("fp_order", DW'(o_g[1]), DW'(2'b01));
      repeat ($urandom_range(0, 3)) tick();
      mack = 1'b1;
      tick();
      mack = 1'b0;
      k = 0;
      do begin
        tick();
        k++;
      end while (!obs_en_rr && k < 8);
      chk("ack_to_enable_gap", DW'(k), DW'(3));
    end
    en0 = 1'b0; en1 = 1'b0;
    mack = 1'b1;
    tick();
    mack = 1'b0;
    repeat (3) tick();

    // p1 line write with p0 inputs present but idle; owner drops enable mid-transfer.
    a1 = 32'h0000_1FE0; d1 = {32{8'hA5}}; wr1 = 1'b1; en1 = 1'b1;
    a0 = $urandom; d0 = rnd256(); wr0 = 1'b0;
    repeat (4) tick();
    en1 = 1'b0;
    repeat (2) tick();
    en1 = 1'b1;
    // New p0 request in the same cycle as the ack waits for IDLE.
    en0 = 1'b1; mack = 1'b1;
    tick();
    mack = 1'b0; en1 = 1'b0; wr1 = 1'b0;
    repeat (3) tick();
    mack = 1'b1;
    tick();
    mack = 1'b0; en0 = 1'b0;
    repeat (2) tick();

    // Memory never acks: RR instance flags a timeout and keeps waiting; reset clears it.
    rst = 1'b1;
    tick();
    rst = 1'b0; en0 = 1'b1; a0 = $urandom;
    repeat (14) tick();
    chk("err_sticky", DW'(o_err[0]), DW'(1'b1));
    chk("busy_hold", DW'(o_busy[0]), DW'(1'b1));
    chk("no_timeout_fp", DW'(o_err[1]), DW'(1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0; en0 = 1'b0;
    chk("rst_err", DW'(o_err[0]), DW'(1'b0));
    chk("rst_busy", DW'(o_busy[0]), DW'(1'b0));
    chk("rst_men", DW'(o_men[0]), DW'(1'b0));
    tick();

    // Randomized traffic: ports hold until acked by the RR instance, occasional drops and resets.
    for (int i = 0; i < 400; i++) begin
      if (!en0 && $urandom_range(0, 2) == 0) begin
        en0 = 1'b1; wr0 = 1'($urandom); a0 = $urandom; d0 = rnd256();
      end else if (en0 && (lack0 || $urandom_range(0, 15) == 0)) begin
        en0 = 1'b0;
      end
      if (!en1 && $urandom_range(0, 2) == 0) begin
        en1 = 1'b1; wr1 = 1'($urandom); a1 = $urandom; d1 = rnd256();
      end else if (en1 && (lack1 || $urandom_range(0, 15) == 0)) begin
        en1 = 1'b0;
      end
      mack = ($urandom_range(0, 3) == 0);
      mdi  = rnd256();
      rst  = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
